// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU LSU (port 0)
// and the debug/DMA loader (port 1). Optional memory-ack watchdog: DMEM_ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [3:0]        p0_sign_mask,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p1_sign_mask,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_sign_mask,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ack,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                   state, state_nxt;
    logic                     last_grant;
    logic                     win;
    logic                     win_we;
    logic                     any_req;
    logic                     tmo;
    logic                     done;
    logic [1:0][DATA_W-1:0]   rdata_q;

    assign any_req = p0_req | p1_req;
    // Contention goes to the port that did not win last; a lone requester always wins.
    assign win     = (p0_req & p1_req) ? ~last_grant : p1_req;
    assign win_we  = win ? p1_we : p0_we;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo = (state == ISSUE) && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside ISSUE, so every transaction starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != ISSUE)
                tmo_cnt <= '0;
            else if (!mem_ack)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (done)
                err_q <= tmo;
            else if (state == RESP)
                err_q <= 1'b0;
        end
    end

    assign p0_err = p0_ack & err_q;
    assign p1_err = p1_ack & err_q;
`else
    assign tmo    = 1'b0;
    assign p0_err = 1'b0;
    assign p1_err = 1'b0;
`endif

    assign done = (state == ISSUE) && (mem_ack || tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (done)    state_nxt = RESP;
            RESP:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // The mem_* registers double as the request buffers for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= 1'b1;
            grant_id       <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            rdata_q        <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant     <= win;
                grant_id       <= win;
                mem_memread    <= ~win_we;
                mem_memwrite   <= win_we;
                mem_addr       <= win ? p1_addr      : p0_addr;
                mem_write_data <= win ? p1_wdata     : p0_wdata;
                mem_sign_mask  <= win ? p1_sign_mask : p0_sign_mask;
            end
            if (done) begin
                mem_memread       <= 1'b0;
                mem_memwrite      <= 1'b0;
                rdata_q[grant_id] <= tmo ? DATA_W'(32'hDEAD_BEEF) : mem_read_data;
            end
        end
    end

    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign p0_ack   = (state == RESP) && !grant_id;
    assign p1_ack   = (state == RESP) &&  grant_id;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a per-cycle vector table for single
// transactions plus hand-written multi-cycle sequences (contention, reset, wait/timeout).
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_sign_mask, p1_sign_mask;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_ack;
    logic        busy, grant_id;

    int nvec = 0;
    int nerr = 0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_read_data(mem_read_data), .mem_ack(mem_ack),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0, we0;
        logic [31:0] a0, d0;
        logic [3:0]  m0;
        logic        r1, we1;
        logic [31:0] a1, d1;
        logic [3:0]  m1;
        logic        mack;
        logic [31:0] mrd;
    } stim_t;

    typedef struct packed {
        logic        rd, wr;
        logic [31:0] maddr, mwd;
        logic [3:0]  mmask;
        logic        ack0, ack1;
        logic [31:0] rd0, rd1;
        logic        busy, gid;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_sign_mask = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_sign_mask = 0;
        mem_ack = 0; mem_read_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    // Memory answers after k wait cycles with addr ^ 0x5A5A0000; checks that the
    // n completions come back on the ports listed in ord (bit i = port of i-th ack).
    task automatic run(input int k, input int n, input bit drop, input logic [3:0] ord, input string nm);
        int got = 0;
        int wc  = 0;
        logic p;
        for (int c = 0; c < 100 && got < n; c++) begin
            if (p0_ack || p1_ack) begin
                p = ord[got];
                chk($sformatf("%s ack%0d port", nm, got), {30'd0, p1_ack, p0_ack}, p ? 32'd2 : 32'd1);
                chk($sformatf("%s ack%0d grant_id", nm, got), {31'd0, grant_id}, {31'd0, p});
                chk($sformatf("%s ack%0d rdata", nm, got), p ? p1_rdata : p0_rdata,
                    (p ? p1_addr : p0_addr) ^ 32'h5A5A_0000);
                chk($sformatf("%s ack%0d err", nm, got), {30'd0, p1_err, p0_err}, 32'd0);
                if (drop) begin
                    if (p) p1_req = 0; else p0_req = 0;
                end
                got++;
            end
            if (mem_memread || mem_memwrite) begin
                if (wc == k) begin
                    mem_ack = 1; mem_read_data = mem_addr ^ 32'h5A5A_0000; wc = 0;
                end else begin
                    mem_ack = 0; wc++;
                end
            end else begin
                mem_ack = 0; wc = 0;
            end
            tick();
        end
        mem_ack = 0;
        chk({nm, " completions"}, got, n);
    endtask

    initial begin
        idle_inputs();
        do_reset();

        //              r0 we0 a0            d0            m0    r1 we1 a1            d1            m1    mack mrd              rd wr maddr         mwd           mmask ack0 ack1 rd0           rd1           busy gid
        tbl[0]  = '{'{0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 32'h0,       32'h0,       0, 0}};
        tbl[1]  = '{'{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 32'h0,       32'h0,       0, 0}};
        tbl[2]  = '{'{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       1, 0}};
        tbl[3]  = '{'{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       1, 0}};
        tbl[4]  = '{'{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       4'h0, 1, 32'hA5A50001}, '{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       1, 0}};
        tbl[5]  = '{'{1, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{0, 0, 32'h1004,    32'hCAFE,    4'h2, 1, 0, 32'hA5A50001, 32'h0,       1, 0}};
        tbl[6]  = '{'{0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{0, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'hA5A50001, 32'h0,       0, 0}};
        tbl[7]  = '{'{0, 0, 32'h0,       32'h0,       4'h0, 1, 1, 32'h1008,    32'hFF,      4'h1, 0, 32'h0},       '{0, 0, 32'h1004,    32'hCAFE,    4'h2, 0, 0, 32'hA5A50001, 32'h0,       0, 0}};
        tbl[8]  = '{'{0, 0, 32'h0,       32'h0,       4'h0, 1, 1, 32'h1008,    32'hFF,      4'h1, 1, 32'h12345678}, '{0, 1, 32'h1008,    32'hFF,      4'h1, 0, 0, 32'hA5A50001, 32'h0,       1, 1}};
        tbl[9]  = '{'{0, 0, 32'h0,       32'h0,       4'h0, 1, 1, 32'h1008,    32'hFF,      4'h1, 0, 32'h0},       '{0, 0, 32'h1008,    32'hFF,      4'h1, 0, 1, 32'hA5A50001, 32'h12345678, 1, 1}};
        tbl[10] = '{'{0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 32'h0,       32'h0,       4'h0, 1, 32'hFFFFFFFF}, '{0, 0, 32'h1008,    32'hFF,      4'h1, 0, 0, 32'hA5A50001, 32'h12345678, 0, 1}};
        tbl[11] = '{'{0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 32'h0,       32'h0,       4'h0, 0, 32'h0},       '{0, 0, 32'h1008,    32'hFF,      4'h1, 0, 0, 32'hA5A50001, 32'h12345678, 0, 1}};

        for (int i = 0; i < 12; i++) begin
            p0_req = tbl[i].s.r0; p0_we = tbl[i].s.we0; p0_addr = tbl[i].s.a0;
            p0_wdata = tbl[i].s.d0; p0_sign_mask = tbl[i].s.m0;
            p1_req = tbl[i].s.r1; p1_we = tbl[i].s.we1; p1_addr = tbl[i].s.a1;
            p1_wdata = tbl[i].s.d1; p1_sign_mask = tbl[i].s.m1;
            mem_ack = tbl[i].s.mack; mem_read_data = tbl[i].s.mrd;
            chk($sformatf("v%0d strobes", i), {30'd0, mem_memread, mem_memwrite}, {30'd0, tbl[i].e.rd, tbl[i].e.wr});
            chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e.maddr);
            chk($sformatf("v%0d mem_write_data", i), mem_write_data, tbl[i].e.mwd);
            chk($sformatf("v%0d mem_sign_mask", i), {28'd0, mem_sign_mask}, {28'd0, tbl[i].e.mmask});
            chk($sformatf("v%0d acks", i), {30'd0, p1_ack, p0_ack}, {30'd0, tbl[i].e.ack1, tbl[i].e.ack0});
            chk($sformatf("v%0d errs", i), {30'd0, p1_err, p0_err}, 32'd0);
            chk($sformatf("v%0d p0_rdata", i), p0_rdata, tbl[i].e.rd0);
            chk($sformatf("v%0d p1_rdata", i), p1_rdata, tbl[i].e.rd1);
            chk($sformatf("v%0d busy/gid", i), {30'd0, busy, grant_id}, {30'd0, tbl[i].e.busy, tbl[i].e.gid});
            tick();
        end

        // Continuous requests on both ports from reset alternate 0,1,0,1.
        do_reset();
        p0_addr = 32'h100; p1_addr = 32'h200;
        p0_req = 1; p1_req = 1;
        run(0, 4, 0, 4'b1010, "contend");

        // Port 1 raises its request while port 0 waits 5 cycles on memory.
        do_reset();
        p0_addr = 32'h300; p0_req = 1;
        tick();
        p1_addr = 32'h400; p1_req = 1;
        run(5, 2, 1, 4'b10, "busy");
        for (int i = 0; i < 3; i++) begin
            chk("busy no extra ack", {30'd0, p1_ack, p0_ack}, 32'd0);
            tick();
        end

        // Asynchronous reset in the middle of ISSUE.
        p0_addr = 32'h500; p0_req = 1;
        tick();
        tick();
        chk("pre-reset read strobe", {31'd0, mem_memread}, 32'd1);
        rst_n = 0;
        #1;
        chk("async rst strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        chk("async rst busy/ack", {29'd0, busy, p1_ack, p0_ack}, 32'd0);
        chk("async rst mem_addr", mem_addr, 32'd0);
        chk("async rst p0_rdata", p0_rdata, 32'd0);
        @(negedge clk);
        p0_addr = 32'h600; p1_addr = 32'h700;
        p0_req = 1; p1_req = 1;
        rst_n = 1;
        tick();
        chk("post-reset first grant", {31'd0, grant_id}, 32'd0);
        run(0, 2, 1, 4'b10, "post-reset");

`ifdef DMEM_ARB_TIMEOUT_EN
        // Watchdog: no mem_ack, expect 8 ISSUE cycles then an error completion.
        begin
            int cnt = 0;
            p0_addr = 32'h800; p0_we = 0; p0_req = 1;
            tick();
            while (mem_memread && cnt < 40) begin
                cnt++;
                tick();
            end
            chk("timeout issue cycles", cnt, 8);
            chk("timeout ack/err", {29'd0, p0_ack, p0_err, p1_ack}, 32'b110);
            chk("timeout rdata", p0_rdata, 32'hDEAD_BEEF);
            p0_req = 0; mem_ack = 1; mem_read_data = 32'h1111_2222;
            tick();
            mem_ack = 0;
            chk("late ack ignored", {29'd0, busy, p1_ack, p0_ack}, 32'd0);
            chk("late ack rdata", p0_rdata, 32'hDEAD_BEEF);
        end
`else
        // Without the watchdog ISSUE waits for mem_ack indefinitely.
        begin
            int hold = 0;
            p0_addr = 32'h800; p0_we = 0; p0_req = 1;
            tick();
            for (int i = 0; i < 20; i++) begin
                if (mem_memread && busy && !p0_ack) hold++;
                tick();
            end
            chk("long wait strobe held", hold, 20);
            mem_ack = 1; mem_read_data = 32'h0000_0077;
            tick();
            mem_ack = 0;
            chk("long wait ack/err", {29'd0, p0_ack, p0_err, p1_ack}, 32'b100);
            chk("long wait rdata", p0_rdata, 32'h0000_0077);
            p0_req = 0;
            tick();
            chk("long wait idle", {31'd0, busy}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory load/store port between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: debug/DMA loader.
- Sits between the requesters and the data cache / data memory.
- Latches one request, drives the memory-side read/write strobes until the memory acknowledges, then returns the read data and a one-cycle ack to the winner.
- Round-robin arbitration; one transaction in flight at a time.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 64, memory-ack watchdog limit (used only with DMEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pN_req  in  1  port N (N=0,1) request; held high until pN_ack.
- pN_we  in  1  1=store, 0=load; stable while pN_req.
- pN_addr  in  ADDR_W  byte address; stable while pN_req.
- pN_wdata  in  DATA_W  store data.
- pN_sign_mask  in  4  access size/sign code, passed through unchanged.
- pN_rdata  out  DATA_W  load data, valid when pN_ack.
- pN_ack  out  1  one-cycle completion pulse.
- pN_err  out  1  one-cycle error pulse, coincident with pN_ack.
- mem_memread  out  1  read strobe to memory.
- mem_memwrite  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  latched address.
- mem_write_data  out  DATA_W  latched store data.
- mem_sign_mask  out  4  latched sign mask.
- mem_read_data  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  port owning the current or last transaction.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including pN_rdata, mem_* and busy.
  - last_grant=1, so port 0 wins the first contention.
  - A reset mid-transaction aborts it: no ack is issued and the strobes drop immediately.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any pN_req is high, pick the winner:
    - Only one port requesting: that port wins.
    - Both requesting: the port != last_grant wins.
  - Latch the winner's we/addr/wdata/sign_mask into buffers.
  - Set grant_id=last_grant=winner; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_memread = ~we_buf, mem_memwrite = we_buf; mem_addr/data/mask driven from the buffers.
  - Strobes are registered, so they rise the cycle after the grant and stay level until mem_ack is sampled high.
  - On mem_ack: latch mem_read_data into rdata_buf (stores latch it too; value is don't-care) and go to RESP.
  - The strobes fall in the cycle following the mem_ack edge.
- RESP:
  - p[grant_id]_ack=1 and p[grant_id]_rdata=rdata_buf for exactly one cycle.
  - The other port's ack stays 0.
  - Next state IDLE.
  - pN_rdata holds its value after ack until the next RESP for that port.
- Latency:
  - Request sampled in IDLE at edge t → strobes high from t+1 → mem_ack at edge t+1+k (k≥0 wait cycles) → ack cycle t+2+k.
  - Minimum request-to-ack is 3 cycles.
- Requester rule: drop pN_req on the edge that samples pN_ack. A request still high in the IDLE after RESP is treated as a new request.
- Fairness:
  - Continuous requests on both ports alternate strictly 0,1,0,1.
  - A lone requester may win back-to-back.
- Boundary conditions:
  - pN_req rising during ISSUE/RESP waits; it is never dropped.
  - Both requests rising in the same IDLE cycle: the round-robin rule decides.
  - mem_ack while in IDLE or RESP is ignored.
- pN_err is 0 unless DMEM_ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle without mem_ack.
  - At count == TIMEOUT_CYCLES-1 without ack: drop the strobes, load rdata_buf=32'hDEAD_BEEF, go to RESP.
  - In that RESP, assert both pN_ack and pN_err for the granted port.
  - A mem_ack arriving after the timeout is ignored.
- Undefined: no counter; ISSUE waits for mem_ack indefinitely; pN_err is tied 0.

Test Plan:
- Single load: p0 load addr 0x1004, memory acks after 2 wait cycles with 0xA5A5_0001 → mem_memread high 3 cycles, mem_addr=0x1004, p0_ack one cycle with p0_rdata=0xA5A5_0001, p1_ack=0.
- Single store: p1 store addr 0x1008, wdata 0x0000_00FF, mask 4'b0001 → mem_memwrite high, mem_write_data=0xFF, mem_sign_mask=0001, p1_ack after mem_ack, grant_id=1.
- Contention: p0 and p1 both request continuously for 4 transactions from reset → grants in order 0,1,0,1; each ack matches its own request's read data.
- Request during busy: p1 raises req while p0 is in ISSUE with a 5-cycle memory wait → p1 is serviced in the next IDLE; no lost or duplicated ack.
- Async reset mid-ISSUE: rst_n low for half a cycle → strobes and busy drop without waiting for a clock edge; no ack; after release, p0 wins the first contention.
- Timeout (DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ack never asserted → after 8 ISSUE cycles p0_ack=p0_err=1 and p0_rdata=0xDEADBEEF; a late mem_ack is ignored.
